// File: rtl/dcache_pkg.sv
// Shared types, constants and address-split helpers for the direct-mapped
// write-through data cache.
package dcache_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MEM_READ  = 2'd1,
    S_MEM_WRITE = 2'd2,
    S_FLUSH     = 2'd3
  } state_e;

  // Low index_w bits select the line; callers cast down to their index width.
  function automatic logic [WORD_W-1:0] addr_index(input logic [WORD_W-1:0] addr,
                                                   input int index_w);
    logic [WORD_W-1:0] mask;
    mask = (32'd1 << index_w) - 32'd1;
    return addr & mask;
  endfunction

  function automatic logic [WORD_W-1:0] addr_tag(input logic [WORD_W-1:0] addr,
                                                 input int index_w);
    return addr >> index_w;
  endfunction

  function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] value);
    return (value == {WORD_W{1'b1}}) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// Valid/tag/data storage for the data cache: combinational read, synchronous
// write and a single-cycle invalidate-all.
module dcache_tag_array
  import dcache_pkg::*;
#(
  parameter int LINES   = 64,
  parameter int INDEX_W = $clog2(LINES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic [INDEX_W-1:0]        rd_index,
  output logic                      rd_valid,
  output logic [WORD_W-INDEX_W-1:0] rd_tag,
  output logic [WORD_W-1:0]         rd_data,
  input  logic                      wr_en,
  input  logic [INDEX_W-1:0]        wr_index,
  input  logic [WORD_W-INDEX_W-1:0] wr_tag,
  input  logic [WORD_W-1:0]         wr_data
);

  logic [LINES-1:0]          valid_q;
  logic [LINES-1:0]          valid_d;
  logic [WORD_W-INDEX_W-1:0] tag_mem  [LINES];
  logic [WORD_W-1:0]         data_mem [LINES];

  always_comb begin
    valid_d = valid_q;
    if (clear) begin
      valid_d = {LINES{1'b0}};
    end else if (wr_en) begin
      valid_d[wr_index] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= {LINES{1'b0}};
    end else begin
      valid_q <= valid_d;
    end
  end

  // A write coinciding with reset belongs to an aborted transaction and is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller between
// the load/store stage and main memory; one-cycle read hits, hit/miss counters.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int LINES       = 64,
  parameter int INDEX_W     = $clog2(LINES),
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpuReq,
  input  logic              cpuWrite,
  input  logic [WORD_W-1:0] cpuAddress,
  input  logic [WORD_W-1:0] cpuWriteData,
  input  logic              flush,
  output logic              cpuDone,
  output logic [WORD_W-1:0] cpuReadData,
  output logic              busy,
  output logic [WORD_W-1:0] memAddress,
  output logic              memReadEnable,
  output logic              memWriteEnable,
  output logic [WORD_W-1:0] memDataIn,
  input  logic [WORD_W-1:0] memDataOut,
  output logic [WORD_W-1:0] hitCount,
  output logic [WORD_W-1:0] missCount
);

  localparam int TAG_W = WORD_W - INDEX_W;
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_LATENCY - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              wr_hit_q, wr_hit_d;
  logic              done_q, done_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_din_q, mem_din_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [WORD_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [WORD_W-1:0] miss_cnt_q, miss_cnt_d;

  logic [INDEX_W-1:0] rd_index_s, wr_index_s;
  logic [TAG_W-1:0]   cpu_tag_s, wr_tag_s, rd_tag_s;
  logic [WORD_W-1:0]  rd_data_s, line_wdata_s;
  logic               rd_valid_s, hit_s, line_we_s, clear_s;

  // Lookup uses the live request address; fills and updates use the captured one.
  assign rd_index_s = INDEX_W'(addr_index(cpuAddress, INDEX_W));
  assign cpu_tag_s  = TAG_W'(addr_tag(cpuAddress, INDEX_W));
  assign wr_index_s = INDEX_W'(addr_index(mem_addr_q, INDEX_W));
  assign wr_tag_s   = TAG_W'(addr_tag(mem_addr_q, INDEX_W));
  assign hit_s      = rd_valid_s && (rd_tag_s == cpu_tag_s);
  assign clear_s    = (state_q == S_FLUSH);

  dcache_tag_array #(
    .LINES   (LINES),
    .INDEX_W (INDEX_W)
  ) u_tag_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear_s),
    .rd_index (rd_index_s),
    .rd_valid (rd_valid_s),
    .rd_tag   (rd_tag_s),
    .rd_data  (rd_data_s),
    .wr_en    (line_we_s),
    .wr_index (wr_index_s),
    .wr_tag   (wr_tag_s),
    .wr_data  (line_wdata_s)
  );

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    wr_hit_d     = wr_hit_q;
    done_d       = 1'b0;
    rdata_d      = rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    mem_re_d     = 1'b0;
    mem_we_d     = 1'b0;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    line_we_s    = 1'b0;
    line_wdata_s = mem_din_q;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          state_d = S_FLUSH;
        end else if (cpuReq && !done_q) begin
          if (cpuWrite) begin
            state_d    = S_MEM_WRITE;
            mem_addr_d = cpuAddress;
            mem_din_d  = cpuWriteData;
            mem_we_d   = 1'b1;
            wr_hit_d   = hit_s;
            wait_d     = {CNT_W{1'b0}};
          end else if (hit_s) begin
            done_d    = 1'b1;
            rdata_d   = rd_data_s;
            hit_cnt_d = sat_inc(hit_cnt_q);
          end else begin
            state_d    = S_MEM_READ;
            mem_addr_d = cpuAddress;
            mem_re_d   = 1'b1;
            wait_d     = {CNT_W{1'b0}};
            miss_cnt_d = sat_inc(miss_cnt_q);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MEM_READ: begin
        if (wait_q == LAST_WAIT) begin
          line_we_s    = 1'b1;
          line_wdata_s = memDataOut;
          rdata_d      = memDataOut;
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end else begin
          wait_d   = wait_q + CNT_W'(1);
          mem_re_d = 1'b1;
        end
      end
      S_MEM_WRITE: begin
        if (wait_q == LAST_WAIT) begin
          line_we_s = wr_hit_q;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wait_d   = wait_q + CNT_W'(1);
          mem_we_d = 1'b1;
        end
      end
      S_FLUSH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wait_q     <= {CNT_W{1'b0}};
      wr_hit_q   <= 1'b0;
      done_q     <= 1'b0;
      rdata_q    <= 32'd0;
      mem_addr_q <= 32'd0;
      mem_din_q  <= 32'd0;
      mem_re_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      wr_hit_q   <= wr_hit_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_re_q   <= mem_re_d;
      mem_we_q   <= mem_we_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign cpuDone        = done_q;
  assign cpuReadData    = rdata_q;
  assign busy           = (state_q != S_IDLE);
  assign memAddress     = mem_addr_q;
  assign memReadEnable  = mem_re_q;
  assign memWriteEnable = mem_we_q;
  assign memDataIn      = mem_din_q;
  assign hitCount       = hit_cnt_q;
  assign missCount      = miss_cnt_q;

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: a line-occupancy reference model
// predicts every response; a monitor checks whatever the DUT presents.
module tb_dcache_controller;

  localparam int LINES       = 64;
  localparam int MEM_LATENCY = 2;
  localparam int MEM_WORDS   = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpuReq = 1'b0;
  logic        cpuWrite = 1'b0;
  logic [31:0] cpuAddress = 32'd0;
  logic [31:0] cpuWriteData = 32'd0;
  logic        flush = 1'b0;
  logic        cpuDone;
  logic [31:0] cpuReadData;
  logic        busy;
  logic [31:0] memAddress;
  logic        memReadEnable;
  logic        memWriteEnable;
  logic [31:0] memDataIn;
  logic [31:0] memDataOut = 32'd0;
  logic [31:0] hitCount;
  logic [31:0] missCount;

  dcache_controller #(
    .LINES       (LINES),
    .MEM_LATENCY (MEM_LATENCY)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpuReq         (cpuReq),
    .cpuWrite       (cpuWrite),
    .cpuAddress     (cpuAddress),
    .cpuWriteData   (cpuWriteData),
    .flush          (flush),
    .cpuDone        (cpuDone),
    .cpuReadData    (cpuReadData),
    .busy           (busy),
    .memAddress     (memAddress),
    .memReadEnable  (memReadEnable),
    .memWriteEnable (memWriteEnable),
    .memDataIn      (memDataIn),
    .memDataOut     (memDataOut),
    .hitCount       (hitCount),
    .missCount      (missCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_write;
    logic [31:0] addr;
    logic [31:0] data;
    int          lat;
    int          rd_strobes;
    int          wr_strobes;
    int          hits;
    int          misses;
    int          issue_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  logic        ref_valid [LINES];
  logic [31:0] ref_addr  [LINES];
  int ref_hits = 0;
  int ref_misses = 0;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rd_seen = 0;
  int wr_seen = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Main memory: responds combinationally-enough by the next posedge, stores on write strobes.
  initial forever begin
    @(negedge clk);
    if (memWriteEnable) mem[memAddress[7:0]] = memDataIn;
    memDataOut = mem[memAddress[7:0]];
  end

  // Monitor: strobe legality every cycle, full response check on each cpuDone.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      if (memReadEnable || memWriteEnable) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL strobe_no_txn: memAddress %h with no outstanding request", memAddress);
        end else begin
          check("strobe_exclusive", {31'd0, memReadEnable & memWriteEnable}, 32'd0);
          check("mem_address", memAddress, sb[0].addr);
          if (memWriteEnable) check("mem_data_in", memDataIn, sb[0].data);
        end
      end
      if (memReadEnable)  rd_seen++;
      if (memWriteEnable) wr_seen++;
      if (cpuDone) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: cpuReadData %h with no outstanding request", cpuReadData);
        end else begin
          e = sb.pop_front();
          check("latency", 32'(cyc - e.issue_cyc), 32'(e.lat));
          if (!e.is_write) check("read_data", cpuReadData, e.data);
          check("rd_strobe_cycles", 32'(rd_seen), 32'(e.rd_strobes));
          check("wr_strobe_cycles", 32'(wr_seen), 32'(e.wr_strobes));
          check("hit_count", hitCount, 32'(e.hits));
          check("miss_count", missCount, 32'(e.misses));
        end
        rd_seen = 0;
        wr_seen = 0;
      end
    end else begin
      rd_seen = 0;
      wr_seen = 0;
    end
  end

  task automatic ref_reset();
    for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
    ref_hits   = 0;
    ref_misses = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_done", {31'd0, cpuDone}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_re", {31'd0, memReadEnable}, 32'd0);
    check("rst_we", {31'd0, memWriteEnable}, 32'd0);
    check("rst_rdata", cpuReadData, 32'd0);
    check("rst_maddr", memAddress, 32'd0);
    check("rst_mdin", memDataIn, 32'd0);
    check("rst_hits", hitCount, 32'd0);
    check("rst_misses", missCount, 32'd0);
  endtask

  // Cache model: each line remembers which full address it holds; memory is the truth for data.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic with_flush);
    exp_t e;
    int   idx;
    logic hit;
    logic seen;
    @(negedge clk);
    idx = int'(addr % LINES);
    if (with_flush) for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
    hit = ref_valid[idx] && (ref_addr[idx] == addr);
    e.is_write = wr; e.addr = addr; e.issue_cyc = cyc;
    e.rd_strobes = 0; e.wr_strobes = 0;
    if (wr) begin
      ref_mem[addr[7:0]] = data;
      e.data = data; e.lat = MEM_LATENCY + 1; e.wr_strobes = MEM_LATENCY;
    end else if (hit) begin
      ref_hits++;
      e.data = ref_mem[addr[7:0]]; e.lat = 1;
    end else begin
      ref_misses++;
      ref_valid[idx] = 1'b1; ref_addr[idx] = addr;
      e.data = ref_mem[addr[7:0]]; e.lat = MEM_LATENCY + 1; e.rd_strobes = MEM_LATENCY;
    end
    if (with_flush) e.lat += 2;
    e.hits = ref_hits; e.misses = ref_misses;
    sb.push_back(e);
    cpuReq = 1'b1; cpuWrite = wr; cpuAddress = addr; cpuWriteData = data; flush = with_flush;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      flush = 1'b0;
      if (cpuDone) seen = 1'b1;
    end
    cpuReq = 1'b0;
    if (!seen) begin
      tests++; fails++;
      $display("FAIL timeout: no cpuDone for addr %h within 40 cycles", addr);
      sb.delete();
    end
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < MEM_WORDS; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[8'h10] = 32'h12345678;
    ref_mem[8'h10] = 32'h12345678;
    ref_reset();

    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;

    do_req(1'b0, 32'h10, 32'd0, 1'b0);
    do_req(1'b0, 32'h10, 32'd0, 1'b0);
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    do_req(1'b0, 32'h10, 32'd0, 1'b0);
    do_req(1'b1, 32'h20, 32'hCAFEF00D, 1'b0);
    do_req(1'b0, 32'h20, 32'd0, 1'b0);
    do_req(1'b0, 32'h10, 32'd0, 1'b1);
    do_req(1'b0, 32'h50, 32'd0, 1'b0);
    do_req(1'b0, 32'h10, 32'd0, 1'b0);

    // Reset in the last MEM_READ cycle of a miss on 0x30.
    @(negedge clk);
    sb.push_back('{is_write: 1'b0, addr: 32'h30, data: 32'd0, lat: 0, rd_strobes: 0,
                   wr_strobes: 0, hits: 0, misses: 0, issue_cyc: cyc});
    cpuReq = 1'b1; cpuWrite = 1'b0; cpuAddress = 32'h30; flush = 1'b0;
    @(negedge clk);
    check("busy_in_read", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0; cpuReq = 1'b0;
    sb.delete();
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    ref_reset();
    do_req(1'b0, 32'h30, 32'd0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      do_req(($urandom_range(0, 2) == 0), 32'($urandom_range(0, MEM_WORDS - 1)), $urandom,
             ($urandom_range(0, 15) == 0));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-through, no-write-allocate data cache. One 32-bit word per line.
- Sits between the MIPS32 load/store stage (upstream) and MainMemoryModule (downstream).
- Turns CPU word requests into main-memory read/write strobes held for a fixed latency window.
- Serves read hits in one cycle and keeps hit/miss statistics.

Parameters:
- LINES, 64, number of cache lines; power of two, at least 2.
- INDEX_W, $clog2(LINES), index width; derived, never overridden.
- MEM_LATENCY, 2, cycles each main-memory strobe is held; at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- cpuReq  in  1  request valid; held high by the requester until cpuDone.
- cpuWrite  in  1  1 = store, 0 = load; stable while cpuReq is high.
- cpuAddress  in  32  word address; stable while cpuReq is high.
- cpuWriteData  in  32  store data.
- flush  in  1  invalidate all lines.
- cpuDone  out  1  one-cycle completion pulse.
- cpuReadData  out  32  load result; valid while cpuDone is high.
- busy  out  1  high whenever the FSM is not in IDLE.
- memAddress  out  32  to MainMemoryModule address.
- memReadEnable  out  1  to MainMemoryModule readEnable.
- memWriteEnable  out  1  to MainMemoryModule writeEnable.
- memDataIn  out  32  to MainMemoryModule dataIn.
- memDataOut  in  32  from MainMemoryModule dataOut.
- hitCount  out  32  saturating read-hit counter.
- missCount  out  32  saturating read-miss counter.

Behaviour:
- Address split: index = cpuAddress[INDEX_W-1:0]; tag = cpuAddress[31:INDEX_W].
- Storage per line: valid bit, tag of 32-INDEX_W bits, 32-bit data.
- Reset (rst_n=0 at a clock edge):
  - all valid bits cleared; FSM goes to IDLE.
  - cpuDone, busy, memReadEnable and memWriteEnable are 0.
  - cpuReadData, memAddress, memDataIn, hitCount and missCount are 0.
  - reset mid-transaction aborts it with no cpuDone and no line update. An aborted write may already have reached memory; this is acceptable.
- FSM states: IDLE, MEM_READ, MEM_WRITE, FLUSH.
- IDLE:
  - flush=1 goes to FLUSH. Flush has priority over cpuReq; the request stays pending.
  - otherwise cpuReq=1 and cpuDone=0 accepts the request. Address, write flag and data are captured and the lookup is done.
  - the cpuDone=0 condition stops a still-held request from being re-accepted.
- Read hit (valid and tag match):
  - hitCount increments; FSM stays in IDLE.
  - next cycle: cpuDone=1 and cpuReadData = line data. Latency is 1 cycle.
- Read miss:
  - missCount increments; go to MEM_READ.
  - memReadEnable=1 and memAddress = captured address for exactly MEM_LATENCY cycles, counted by the wait counter.
  - on the last of those cycles: sample memDataOut, write the line (valid=1, new tag, data), return to IDLE.
  - next cycle: cpuDone=1 with the fetched data. Latency is MEM_LATENCY+1.
- Write, hit or miss:
  - go to MEM_WRITE.
  - memWriteEnable=1, memAddress and memDataIn driven for MEM_LATENCY cycles.
  - memReadEnable is forced to 0 throughout.
  - on a hit, line data is updated on the last cycle; on a miss, no allocation.
  - next cycle: cpuDone=1. Write counts leave hitCount and missCount unchanged.
- memReadEnable and memWriteEnable are never high together.
- Outside transactions, memAddress and memDataIn hold their last values.
- FLUSH: one cycle; all valid bits cleared; back to IDLE. hitCount and missCount are not cleared.
- flush while busy: ignored until IDLE; the requester must hold flush.
- Counters saturate at 32'hFFFFFFFF.
- Index wrap: addresses LINES apart alias to the same line; a fill replaces the old tag.

Decomposition:
- Shared package dcache_pkg:
  - FSM state enum.
  - constant WORD_W=32.
  - the address-split helper functions (index and tag).
- One sub-module, dcache_tag_array:
  - valid, tag and data storage.
  - synchronous write, combinational read.
  - single-cycle clear-all input.

Test Plan (all with LINES=64, MEM_LATENCY=2):
- Cold read, addr 0x10, memory word 0x12345678 -> memReadEnable high 2 cycles; cpuDone 3 cycles after accept with 0x12345678; missCount=1.
- Repeat read of 0x10 -> cpuDone 1 cycle after accept with 0x12345678; no memory strobe; hitCount=1.
- Write 0xDEADBEEF to 0x10, then read 0x10 -> memWriteEnable 2 cycles with memDataIn=0xDEADBEEF; following read hits and returns 0xDEADBEEF.
- Write 0xCAFEF00D to uncached 0x20, then read 0x20 -> write does not allocate; the read misses and missCount increments.
- Read 0x10, then 0x50 (same index, different tag), then 0x10 -> miss, miss, miss; missCount grows by 3; each returns the correct memory word.
- flush and cpuReq together in IDLE, plus reset asserted during MEM_READ -> flush wins; the read then misses. Reset gives no cpuDone, all outputs 0, and a later read of the same address misses.
